// File: rtl/baccarat_pkg.sv
// Shared baccarat types and helpers: deal FSM states, card value mapping,
// and the score thresholds used by the deal sequencer and datapath scorer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    RST  = 4'd0,
    P1   = 4'd1,
    D1   = 4'd2,
    P2   = 4'd3,
    D2   = 4'd4,
    CHK  = 4'd5,
    P3   = 4'd6,
    CHK3 = 4'd7,
    D3   = 4'd8,
    DONE = 4'd9
  } deal_state_t;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

  // Card code to baccarat value: A..9 count face value, 10/J/Q/K count 0.
  // Invalid codes 0, 14 and 15 also map to 0.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= 4'd1 && code <= 4'd9)
      return code;
    return 4'd0;
  endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Bundle between the deal sequencer and the card datapath.
// slave: sequencer side (scores in, strobes/lights out); master: datapath side.
interface deal_sequencer_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;

  modport slave (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
  );

  modport master (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
  );
endinterface

// File: rtl/deal_sequencer_banker_rule.sv
// Banker third-card rule: given dealer score and player third-card value,
// decide whether the dealer draws. Ports: dscore, v in; draw out.
module banker_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  output logic       draw
);
  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end
endmodule

// File: rtl/deal_sequencer.sv
// Moore FSM sequencing one baccarat hand: load strobes, draw rules, lights.
// Ports: slow_clock, reset (sync, active-high), bus (slave side of the bundle).
module deal_sequencer
  import baccarat_pkg::*;
(
  input logic              slow_clock,
  input logic              reset,
  deal_sequencer_if.slave  bus
);

  deal_state_t state_q;
  deal_state_t state_d;
  logic [3:0]  pv;
  logic        dealer_draw;
  logic        natural;

  assign pv      = card_value(bus.pcard3);
  assign natural = (bus.pscore >= NATURAL_MIN) ||
                   (bus.dscore >= NATURAL_MIN);

  banker_rule u_rule (
    .dscore (bus.dscore),
    .v      (pv),
    .draw   (dealer_draw)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:  state_d = P1;
      P1:   state_d = D1;
      D1:   state_d = P2;
      P2:   state_d = D2;
      D2:   state_d = CHK;
      CHK: begin
        if (natural)
          state_d = DONE;
        else if (bus.pscore < PLAYER_STAND_MIN)
          state_d = P3;
        // Player stands: dealer draws on 0..5.
        else if (bus.dscore < PLAYER_STAND_MIN)
          state_d = D3;
        else
          state_d = DONE;
      end
      P3:   state_d = CHK3;
      CHK3: state_d = dealer_draw ? D3 : DONE;
      D3:   state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset)
      state_q <= RST;
    else
      state_q <= state_d;
  end

  assign bus.load_pcard1 = (state_q == P1);
  assign bus.load_pcard2 = (state_q == P2);
  assign bus.load_pcard3 = (state_q == P3);
  assign bus.load_dcard1 = (state_q == D1);
  assign bus.load_dcard2 = (state_q == D2);
  assign bus.load_dcard3 = (state_q == D3);

  // A tie lights both.
  assign bus.player_win_light =
    (state_q == DONE) && (bus.pscore >= bus.dscore);
  assign bus.dealer_win_light =
    (state_q == DONE) && (bus.dscore >= bus.pscore);

endmodule

// File: doc/deal_sequencer.md
# deal_sequencer

Moore state machine that sequences one hand of baccarat on the card datapath. It pulses one load strobe per state to capture dealt cards into the player and dealer card registers. It applies the third-card drawing rules to the datapath's hand scores and drives the win lights at the end of the hand. It sits between the datapath (card registers, hand scorers, `card7seg` displays) and the top level. One state advances per `slow_clock` edge.

## Interface
- No parameters.
- `slow_clock`  in  1  advances one state per rising edge.
- `reset`  in  1  synchronous, active-high; forces state `RST`.
- `pscore`  in  4  player hand score 0..9 from the datapath, combinational from the card registers.
- `dscore`  in  4  dealer hand score 0..9, same source.
- `pcard3`  in  4  player third-card code: 1=A, 2..10, 11=J, 12=Q, 13=K.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  player card register load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  dealer card register load strobes.
- `player_win_light`, `dealer_win_light`  out  1 each  result lights.

## Operation
- States: `RST`, `P1`, `D1`, `P2`, `D2`, `CHK`, `P3`, `CHK3`, `D3`, `DONE`.
- Outputs are decoded from state only.
- Each `Pn`/`Dn` state asserts exactly its own load strobe. All other states assert no strobe.
- Fixed deal sequence: `RST`→`P1`→`D1`→`P2`→`D2`→`CHK`.
- `CHK` (scores now reflect four cards):
  - Natural: `pscore`≥8 or `dscore`≥8 → `DONE`.
  - Otherwise, `pscore`≤5 → `P3`.
  - Otherwise (player stands on 6/7), `dscore`≤5 → `D3`.
  - Otherwise → `DONE`.
- `P3`→`CHK3` unconditionally.
- `CHK3`: dealer draws when the banker rule holds, → `D3`; else → `DONE`.
- Banker rule, with v = `pcard3` value (codes 10..13 → 0, otherwise the code):
  - `dscore` 0..2: draw.
  - 3: draw unless v=8.
  - 4: draw if v∈2..7.
  - 5: draw if v∈4..7.
  - 6: draw if v∈6..7.
  - 7..9: stand.
- `D3`→`DONE`.
- `DONE` holds until reset.
- Lights are driven only in `DONE`:
  - `pscore`>`dscore` → player light only.
  - `dscore`>`pscore` → dealer light only.
  - Equal → both lights.
- `pcard3` codes 0, 14 and 15 are invalid; treat them as v=0.

## Timing
- Reset values (state `RST`): every strobe 0, both lights 0.
- Reset has priority over every transition.
- Reset asserted in any state → `RST` at the next edge. A hand in progress is abandoned; clearing the card registers is the datapath's job.
- Edge numbering: edge k is the k-th rising edge with `reset` low.
- State after each edge on the fixed path: edge 1 `P1`, 2 `D1`, 3 `P2`, 4 `D2`, 5 `CHK`.
- Hand end, by case:
  - Natural: `DONE` at edge 6.
  - Dealer draws only: `D3` at 6, `DONE` at 7.
  - Player draws only: `P3` at 6, `CHK3` at 7, `DONE` at 8.
  - Both draw: `P3` at 6, `CHK3` at 7, `D3` at 8, `DONE` at 9.
- Each strobe is high for exactly one cycle. The datapath captures the card on the edge that ends that cycle.
- Scores and `pcard3` are sampled only in `CHK`/`CHK3`, one cycle after the relevant loads. Their values in other states are don't-care.
- Lights in `DONE` follow the scores combinationally. The scores are stable there because no further loads occur.

## Structure
- Package `baccarat_pkg` holds:
  - the state enum `deal_state_t`;
  - a card-value function (code→0..9);
  - the constant `NATURAL_MIN = 8`;
  - the constant `PLAYER_STAND_MIN = 6`.
  The datapath scorer reuses the card-value function.
- Sub-module `banker_rule`: combinational (`dscore`, v) → draw bit.
- `deal_sequencer` holds the state register, next-state logic and output decode.

## Test plan
- Natural: `pscore`=8, `dscore`=3 at `CHK`.
  - `DONE` at edge 6, player light 1, dealer light 0.
  - `load_pcard3` and `load_dcard3` never asserted.
- Player draws, dealer stands: `pscore`=5, `dscore`=7.
  - `load_pcard3` high only at edge 6.
  - `DONE` at edge 8 with no `load_dcard3`.
  - Final 5 vs 7 → dealer light only.
- Player stands, dealer draws: `pscore`=6, `dscore`=4.
  - `load_dcard3` at edge 6, `DONE` at edge 7.
- Banker rule on third card, `pscore`=2, `dscore`=6:
  - `pcard3`=7 → `load_dcard3` at edge 8.
  - `pcard3`=13 (value 0) → `DONE` at edge 8, no dealer draw.
  - Repeat with `dscore`=3 and `pcard3`=8 → no draw.
- Tie: final `pscore`=`dscore`=5 in `DONE` → both lights 1.
- Reset mid-hand: assert `reset` while in `P3`.
  - Next cycle: state `RST`, all outputs 0.
  - After release, `load_pcard1` pulses at edge 1.
